// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake, sync flush, hazard compare.
// Optional one-entry skid buffer under `EXMEM_SKID_EN` (registered in_ready).
// Ports: clk, rst_n, flush, in_valid/in_ready, out_valid/out_ready,
//   in_*/out_* beat fields, chk_rs1/chk_rs2 -> hazard_rs1/rs2/load.
module ex_mem_pipe_reg #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int F3_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic [XLEN-1:0]   in_alu_result,
   input  logic              in_zero,
   input  logic [F3_W-1:0]   in_funct3,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_mem_write_data,
   input  logic [XLEN-1:0]   in_PC,
   input  logic [XLEN-1:0]   in_nextPC,
   input  logic [REG_AW-1:0] in_write_reg,
   input  logic              in_reg_write,
   input  logic              in_mem_reg,
   input  logic              in_mem_write,
   input  logic              in_branch,
   input  logic              in_jal,
   input  logic              in_jalr,
   output logic [XLEN-1:0]   out_alu_result,
   output logic              out_zero,
   output logic [F3_W-1:0]   out_funct3,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_mem_write_data,
   output logic [XLEN-1:0]   out_PC,
   output logic [XLEN-1:0]   out_nextPC,
   output logic [REG_AW-1:0] out_write_reg,
   output logic              out_reg_write,
   output logic              out_mem_reg,
   output logic              out_mem_write,
   output logic              out_branch,
   output logic              out_jal,
   output logic              out_jalr,
   input  logic [REG_AW-1:0] chk_rs1,
   input  logic [REG_AW-1:0] chk_rs2,
   output logic              hazard_rs1,
   output logic              hazard_rs2,
   output logic              hazard_load
);

   typedef struct packed {
      logic [XLEN-1:0]   alu;
      logic              zero;
      logic [F3_W-1:0]   f3;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   mwd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   npc;
      logic [REG_AW-1:0] wr;
      logic [5:0]        ctl;
   } beat_t;

   beat_t in_b;
   beat_t main_q;
   logic  main_v;
   logic  main_free;
   logic  accept;

   assign in_b = {in_alu_result, in_zero, in_funct3, in_imm,
                  in_mem_write_data, in_PC, in_nextPC, in_write_reg,
                  in_reg_write, in_mem_reg, in_mem_write,
                  in_branch, in_jal, in_jalr};

   assign main_free = !main_v || out_ready;
   assign accept    = in_valid && in_ready;

`ifdef EXMEM_SKID_EN
   beat_t skid_q;
   logic  skid_v;

   assign in_ready = !skid_v;

   // Skid drains into main before any new beat; in_ready is low while
   // the skid is full, so accept and drain never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v <= 1'b0;
         main_q <= '0;
         skid_v <= 1'b0;
         skid_q <= '0;
      end else if (flush) begin
         main_v     <= 1'b0;
         main_q.ctl <= '0;
         skid_v     <= 1'b0;
         skid_q.ctl <= '0;
      end else if (main_free) begin
         if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            skid_v <= 1'b0;
         end else if (accept) begin
            main_q <= in_b;
            main_v <= 1'b1;
         end else begin
            main_v     <= 1'b0;
            main_q.ctl <= '0;
         end
      end else if (accept) begin
         skid_q <= in_b;
         skid_v <= 1'b1;
      end
   end
`else
   assign in_ready = main_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v <= 1'b0;
         main_q <= '0;
      end else if (flush) begin
         main_v     <= 1'b0;
         main_q.ctl <= '0;
      end else if (accept) begin
         main_q <= in_b;
         main_v <= 1'b1;
      end else if (main_free) begin
         // bubble: controls cleared so an ungated MEM stage sees a NOP
         main_v     <= 1'b0;
         main_q.ctl <= '0;
      end
   end
`endif

   assign out_valid = main_v;

   assign {out_alu_result, out_zero, out_funct3, out_imm,
           out_mem_write_data, out_PC, out_nextPC, out_write_reg,
           out_reg_write, out_mem_reg, out_mem_write,
           out_branch, out_jal, out_jalr} = main_q;

   logic wr_live;
   assign wr_live = main_v && out_reg_write && (out_write_reg != '0);

   assign hazard_rs1  = wr_live && (out_write_reg == chk_rs1);
   assign hazard_rs2  = wr_live && (out_write_reg == chk_rs2);
   assign hazard_load = out_mem_reg && (hazard_rs1 || hazard_rs2);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg (base and EXMEM_SKID_EN builds).
// Directed beats; monitor pops expected beats on each output transfer.
module tb_ex_mem_pipe_reg;

`ifdef EXMEM_SKID_EN
   localparam logic SKID = 1'b1;
`else
   localparam logic SKID = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] alu;
      logic        zero;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic [31:0] mwd;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [4:0]  wr;
      logic [5:0]  ctl;
   } beat_t;

   logic        clk, rst_n, flush;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_alu_result, in_imm, in_mem_write_data, in_PC, in_nextPC;
   logic        in_zero;
   logic [2:0]  in_funct3;
   logic [4:0]  in_write_reg;
   logic        in_reg_write, in_mem_reg, in_mem_write;
   logic        in_branch, in_jal, in_jalr;
   logic [31:0] out_alu_result, out_imm, out_mem_write_data;
   logic [31:0] out_PC, out_nextPC;
   logic        out_zero;
   logic [2:0]  out_funct3;
   logic [4:0]  out_write_reg;
   logic        out_reg_write, out_mem_reg, out_mem_write;
   logic        out_branch, out_jal, out_jalr;
   logic [4:0]  chk_rs1, chk_rs2;
   logic        hazard_rs1, hazard_rs2, hazard_load;

   ex_mem_pipe_reg #(.XLEN(32), .REG_AW(5), .F3_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .in_alu_result(in_alu_result), .in_zero(in_zero),
      .in_funct3(in_funct3), .in_imm(in_imm),
      .in_mem_write_data(in_mem_write_data),
      .in_PC(in_PC), .in_nextPC(in_nextPC),
      .in_write_reg(in_write_reg), .in_reg_write(in_reg_write),
      .in_mem_reg(in_mem_reg), .in_mem_write(in_mem_write),
      .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr),
      .out_alu_result(out_alu_result), .out_zero(out_zero),
      .out_funct3(out_funct3), .out_imm(out_imm),
      .out_mem_write_data(out_mem_write_data),
      .out_PC(out_PC), .out_nextPC(out_nextPC),
      .out_write_reg(out_write_reg), .out_reg_write(out_reg_write),
      .out_mem_reg(out_mem_reg), .out_mem_write(out_mem_write),
      .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
      .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
      .hazard_load(hazard_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   beat_t exp_q[$];
   int    d_cmp = 0, d_bad = 0;
   int    m_cmp = 0, m_bad = 0;
   beat_t idle = '0;

   function automatic beat_t mk(input logic [31:0] a, input logic [4:0] wr,
                                input logic [5:0] ctl);
      beat_t b;
      b.alu  = a;
      b.zero = a[4];
      b.f3   = a[6:4];
      b.imm  = a + 32'h100;
      b.mwd  = ~a;
      b.pc   = 32'h1000 + a;
      b.npc  = 32'h1004 + a;
      b.wr   = wr;
      b.ctl  = ctl;
      return b;
   endfunction

   function automatic beat_t out_b();
      return {out_alu_result, out_zero, out_funct3, out_imm,
              out_mem_write_data, out_PC, out_nextPC, out_write_reg,
              out_reg_write, out_mem_reg, out_mem_write,
              out_branch, out_jal, out_jalr};
   endfunction

   task automatic drive(input logic v, input beat_t b,
                        input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      {in_alu_result, in_zero, in_funct3, in_imm, in_mem_write_data,
       in_PC, in_nextPC, in_write_reg, in_reg_write, in_mem_reg,
       in_mem_write, in_branch, in_jal, in_jalr} = b;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      d_cmp++;
      if (act !== req) begin
         d_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         beat_t e;
         m_cmp++;
         if (exp_q.size() == 0) begin
            m_bad++;
            $display("FAIL mon_extra: got %0h want none", out_b());
         end else begin
            e = exp_q.pop_front();
            if (out_b() !== e) begin
               m_bad++;
               $display("FAIL mon_beat: got %0h want %0h", out_b(), e);
            end
         end
      end
   end

   initial begin
      beat_t b;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk_rs1 = '0; chk_rs2 = '0;
      {in_alu_result, in_zero, in_funct3, in_imm, in_mem_write_data,
       in_PC, in_nextPC, in_write_reg, in_reg_write, in_mem_reg,
       in_mem_write, in_branch, in_jal, in_jalr} = idle;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_fields", {31'd0, out_b() == '0}, 32'd1);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // back-to-back streaming
      for (int i = 0; i < 4; i++) begin
         b = mk(32'((i + 1) * 16), 5'(i + 1), 6'b100000);
         exp_q.push_back(b);
         drive(1'b1, b, 1'b1, 1'b0);
         @(negedge clk);
         chk("stream_valid", {31'd0, out_valid}, {31'd0, i > 0});
      end
      drive(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      chk("stream_last", {31'd0, out_valid}, 32'd1);

      // drain: single beat, all controls set
      b = mk(32'h77, 5'd3, 6'h3f);
      exp_q.push_back(b);
      drive(1'b1, b, 1'b1, 1'b0);
      drive(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      chk("drain_held", out_alu_result, 32'h77);
      drive(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_ctl", {26'd0, out_b().ctl}, 32'd0);
      chk("drain_data", out_alu_result, 32'h77);

      // stall three cycles with 0x20 held, 0x30 waiting
      b = mk(32'h20, 5'd2, 6'b100000);
      exp_q.push_back(b);
      drive(1'b1, b, 1'b1, 1'b0);
      b = mk(32'h30, 5'd3, 6'b100000);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, b, 1'b0, 1'b0);
         @(negedge clk);
         chk("stall_data", out_alu_result, 32'h20);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_ready", {31'd0, in_ready},
             {31'd0, (k == 0) ? SKID : 1'b0});
      end
      exp_q.push_back(b);
      drive(1'b1, b, 1'b1, 1'b0);
      @(negedge clk);
      chk("release_ready", {31'd0, in_ready}, {31'd0, ~SKID});
      drive(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      chk("after_stall", out_alu_result, 32'h30);
      drive(1'b0, idle, 1'b1, 1'b0);

      // flush held beat plus incoming beat
      drive(1'b1, mk(32'h55, 5'd4, 6'b101000), 1'b0, 1'b0);
      drive(1'b1, mk(32'h66, 5'd4, 6'b101000), 1'b0, 1'b1);
      @(negedge clk);
      chk("flush_in_ready", {31'd0, in_ready}, {31'd0, SKID});
      drive(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_rw", {31'd0, out_reg_write}, 32'd0);
      chk("flush_mw", {31'd0, out_mem_write}, 32'd0);
      drive(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      chk("flush_gone", {31'd0, out_valid}, 32'd0);

      // flush into an empty stage discards an accepted beat
      drive(1'b1, mk(32'h88, 5'd8, 6'b100000), 1'b1, 1'b1);
      @(negedge clk);
      chk("flush_acc_rdy", {31'd0, in_ready}, 32'd1);
      drive(1'b0, idle, 1'b1, 1'b0);
      @(negedge clk);
      chk("flush_acc_gone", {31'd0, out_valid}, 32'd0);

      // hazard compare against a held load to x5
      b = mk(32'h99, 5'd5, 6'b110000);
      exp_q.push_back(b);
      drive(1'b1, b, 1'b0, 1'b0);
      drive(1'b0, idle, 1'b0, 1'b0);
      chk_rs1 = 5'd5;
      chk_rs2 = 5'd7;
      @(negedge clk);
      chk("haz_rs1", {31'd0, hazard_rs1}, 32'd1);
      chk("haz_rs2", {31'd0, hazard_rs2}, 32'd0);
      chk("haz_load", {31'd0, hazard_load}, 32'd1);
      chk_rs2 = 5'd5;
      #1;
      chk("haz_rs2_b", {31'd0, hazard_rs2}, 32'd1);
      drive(1'b0, idle, 1'b1, 1'b0);

      // x0 destination never collides
      b = mk(32'hA0, 5'd0, 6'b110000);
      exp_q.push_back(b);
      drive(1'b1, b, 1'b0, 1'b0);
      drive(1'b0, idle, 1'b0, 1'b0);
      chk_rs1 = 5'd0;
      chk_rs2 = 5'd0;
      @(negedge clk);
      chk("haz_x0_rs1", {31'd0, hazard_rs1}, 32'd0);
      chk("haz_x0_load", {31'd0, hazard_load}, 32'd0);
      drive(1'b0, idle, 1'b1, 1'b0);
      drive(1'b0, idle, 1'b1, 1'b0);

      // asynchronous reset with a beat held
      drive(1'b1, mk(32'hBB, 5'd6, 6'h3f), 1'b0, 1'b0);
      drive(1'b0, idle, 1'b0, 1'b0);
      chk_rs1 = 5'd6;
      @(negedge clk);
      chk("pre_rst_haz", {31'd0, hazard_rs1}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_fields", {31'd0, out_b() == '0}, 32'd1);
      chk("arst_haz", {29'd0, hazard_rs1, hazard_rs2, hazard_load}, 32'd0);

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               d_cmp + m_cmp, d_bad + m_bad);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register, the successor to the fixed 32-bit stage latch. Adds a valid/ready handshake so MEM-side stalls back-pressure EX, and a synchronous flush for branch/jump redirects. Adds a hazard-compare port so decode can detect a load-use or writeback collision against the instruction held in this stage. Sits between the execute stage (ALU, branch compare) and the memory stage.

Parameters:
XLEN, 32, width of alu_result, imm, mem_write_data, PC, nextPC
REG_AW, 5, register-file address width (write_reg, hazard compare)
F3_W, 3, funct3 width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill held and incoming instruction (sync)
in_valid  in  1  EX presents a beat
in_ready  out  1  stage can accept a beat
out_valid  out  1  MEM-side beat valid
out_ready  in  1  MEM stage consumes beat
in_alu_result / out_alu_result  in/out  XLEN  ALU result
in_zero / out_zero  in/out  1  ALU zero flag
in_funct3 / out_funct3  in/out  F3_W  funct3
in_imm / out_imm  in/out  XLEN  immediate
in_mem_write_data / out_mem_write_data  in/out  XLEN  store data
in_PC / out_PC, in_nextPC / out_nextPC  in/out  XLEN  PC, PC+4
in_write_reg / out_write_reg  in/out  REG_AW  destination register
in_reg_write, in_mem_reg, in_mem_write, in_branch, in_jal, in_jalr / out_*  in/out  1 each  control bits
chk_rs1, chk_rs2  in  REG_AW  decode source registers
hazard_rs1, hazard_rs2  out  1  collision with held instruction
hazard_load  out  1  held instruction is a load (mem_reg) matching either source

Behaviour:
- Reset (rst_n low, async): out_valid=0; all out_* data and control fields=0; skid empty. Release is sync to clk.
- Accept = in_valid && in_ready. Transfer out = out_valid && out_ready.
- Base mode: in_ready = !out_valid || out_ready (combinational). On accept, all in_* fields are registered, out_valid=1, latency 1 cycle. On transfer with no accept, out_valid=0.
- Stall: out_valid && !out_ready -> all out_* hold unchanged; in_ready=0.
- Bubble rule: whenever out_valid goes 0, out_reg_write, out_mem_reg, out_mem_write, out_branch, out_jal, out_jalr are cleared to 0. Data fields hold. A MEM stage ignoring out_valid therefore sees a NOP.
- Flush (priority over everything except reset): next edge out_valid=0, control bits cleared, skid emptied, concurrent input beat discarded even if in_valid && in_ready. in_ready is unaffected by flush.
- Hazards (combinational): hazard_rsN = out_valid && out_reg_write && out_write_reg!=0 && out_write_reg==chk_rsN. hazard_load = out_mem_reg && (hazard_rs1 || hazard_rs2).
- Simultaneous accept and transfer in the same cycle: the new beat replaces the old one with no bubble, sustaining 1 beat/cycle.

Optional Feature:
EXMEM_SKID_EN. When defined, a one-entry skid buffer is added and in_ready becomes a registered signal, in_ready = !skid_valid. This breaks the combinational ready path.
- A beat accepted while the main stage is stalled goes to the skid.
- When the main stage drains, the skid moves to main on the same edge.
- Ordering is preserved. Throughput stays 1 beat/cycle. Flush empties both entries.

When undefined, behaviour is base mode only and there is no skid storage.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 and all outputs 0 immediately, without waiting for clk.
- Streaming: out_ready=1, 4 beats alu_result=0x10,0x20,0x30,0x40 back-to-back -> each appears 1 cycle later, no bubbles, out_valid continuous.
- Stall: hold out_ready=0 for 3 cycles with beat 0x20 held -> out_alu_result stays 0x20, in_ready=0 (base) and input not lost. With EXMEM_SKID_EN, exactly one extra beat 0x30 is accepted and then emerges after 0x20.
- Flush: flush=1 while holding reg_write=1, mem_write=1 and in_valid=1 -> next cycle out_valid=0, out_reg_write=0, out_mem_write=0. The incoming beat never appears.
- Hazard: held write_reg=5, reg_write=1, mem_reg=1, chk_rs1=5 -> hazard_rs1=1, hazard_load=1. With write_reg=0, hazard_rs1=0 and hazard_load=0.
- Drain: single beat, then in_valid=0 with out_ready=1 -> out_valid=0 and all six control bits 0 next cycle.
